// File: rtl/prbs_checker_if.sv
// Word stream and status bundle between an LFSR generator/bench (master) and prbs_checker (slave).
interface prbs_checker_if #(
  parameter int WIDTH = 10,
  parameter int ERR_W = 16
);

  logic             valid_i;
  logic [WIDTH-1:0] data_i;
  logic             clr_cnt_i;
  logic             locked_o;
  logic             err_o;
  logic [ERR_W-1:0] err_cnt_o;

  modport master (
    output valid_i, data_i, clr_cnt_i,
    input  locked_o, err_o, err_cnt_o
  );

  modport slave (
    input  valid_i, data_i, clr_cnt_i,
    output locked_o, err_o, err_cnt_o
  );

endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS word checker with lock tracking and a saturating error counter.
// Define PRBS_CHECKER_BITCNT_EN to count erroneous bits instead of erroneous words.
module prbs_checker #(
  parameter int               WIDTH    = 10,
  parameter logic [WIDTH-1:0] POLINOM  = 10'b00_1000_0001,
  parameter int               LOCK_CNT = 4,
  parameter int               LOSS_CNT = 8,
  parameter int               ERR_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  prbs_checker_if.slave bus
);

`ifdef PRBS_CHECKER_BITCNT_EN
  localparam int INC_W = $clog2(WIDTH + 1);
`else
  localparam int INC_W = 1;
`endif
  localparam int SUM_W = ((ERR_W > INC_W) ? ERR_W : INC_W) + 1;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_nxt;
  logic             has_prev, has_prev_nxt;
  logic [WIDTH-1:0] prev, prev_nxt;
  logic [WIDTH-1:0] exp_word, exp_nxt;
  logic [7:0]       match_cnt, match_nxt;
  logic [7:0]       miss_cnt, miss_nxt;
  logic             err_q, err_nxt;
  logic [ERR_W-1:0] cnt_q, cnt_nxt;
  logic             cnt_inc_en;
  logic             match;
  logic [WIDTH-1:0] mism;
  logic [INC_W-1:0] inc;
  logic [SUM_W-1:0] sum;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {^(x & POLINOM), x[WIDTH-1:1]};
  endfunction

  assign mism = bus.data_i ^ exp_word;

  // Increment amount: one per bad word, or the number of flipped bits when bit counting is built in.
`ifdef PRBS_CHECKER_BITCNT_EN
  always_comb begin
    inc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      inc = inc + INC_W'(mism[i]);
    end
  end
`else
  assign inc = 1'b1;
`endif

  assign sum = SUM_W'(cnt_q) + SUM_W'(inc);

  always_comb begin
    state_nxt    = state;
    has_prev_nxt = has_prev;
    prev_nxt     = prev;
    exp_nxt      = exp_word;
    match_nxt    = match_cnt;
    miss_nxt     = miss_cnt;
    err_nxt      = 1'b0;
    cnt_inc_en   = 1'b0;
    match        = 1'b0;
    if (bus.valid_i) begin
      case (state)
        HUNT: begin
          // An all-zero word is a fixed point of the recurrence, so it must never count towards lock.
          match        = has_prev && (bus.data_i == lfsr_next(prev)) && (bus.data_i != '0);
          prev_nxt     = bus.data_i;
          has_prev_nxt = 1'b1;
          if (!match) begin
            match_nxt = '0;
          end else if (match_cnt + 8'd1 == 8'(LOCK_CNT)) begin
            state_nxt = LOCKED;
            exp_nxt   = lfsr_next(bus.data_i);
            miss_nxt  = '0;
            match_nxt = '0;
          end else begin
            match_nxt = match_cnt + 8'd1;
          end
        end
        LOCKED: begin
          // Prediction free-runs so one corrupted word yields exactly one error.
          exp_nxt = lfsr_next(exp_word);
          if (mism != '0) begin
            err_nxt    = 1'b1;
            cnt_inc_en = 1'b1;
            if (miss_cnt + 8'd1 == 8'(LOSS_CNT)) begin
              state_nxt    = HUNT;
              prev_nxt     = bus.data_i;
              has_prev_nxt = 1'b1;
              match_nxt    = '0;
              miss_nxt     = '0;
            end else begin
              miss_nxt = miss_cnt + 8'd1;
            end
          end else begin
            miss_nxt = '0;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Clear beats a same-cycle increment; the counter pins at all-ones.
  always_comb begin
    cnt_nxt = cnt_q;
    if (bus.clr_cnt_i) begin
      cnt_nxt = '0;
    end else if (cnt_inc_en) begin
      if (sum > SUM_W'({ERR_W{1'b1}})) begin
        cnt_nxt = '1;
      end else begin
        cnt_nxt = sum[ERR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      has_prev  <= 1'b0;
      prev      <= '0;
      exp_word  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state     <= state_nxt;
      has_prev  <= has_prev_nxt;
      prev      <= prev_nxt;
      exp_word  <= exp_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      err_q     <= err_nxt;
      cnt_q     <= cnt_nxt;
    end
  end

  assign bus.locked_o  = (state == LOCKED);
  assign bus.err_o     = err_q;
  assign bus.err_cnt_o = cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a 16-bit and a 4-bit counter instance see the same directed stream.
module tb_prbs_checker;

  localparam int              WIDTH   = 10;
  localparam logic [WIDTH-1:0] POLY   = 10'b00_1000_0001;
  localparam int              LOCKN   = 4;
  localparam int              LOSSN   = 8;

  typedef struct packed {
    logic        locked;
    logic        err;
    logic [15:0] cntWide;
    logic [3:0]  cntNarrow;
  } expect_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic             clr = 1'b0;

  int assertCount = 0;
  int failCount   = 0;
  expect_t sbQueue[$];

  // Independent behavioural model state.
  bit               mLocked;
  bit               mHasPrev;
  logic [WIDTH-1:0] mPrev;
  logic [WIDTH-1:0] mExpect;
  int               mMatch;
  int               mMiss;
  bit               mErr;
  int               mCntWide;
  int               mCntNarrow;

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] flipMask;

  prbs_checker_if #(.WIDTH(WIDTH), .ERR_W(16)) ifWide();
  prbs_checker_if #(.WIDTH(WIDTH), .ERR_W(4))  ifNarrow();

  assign ifWide.valid_i     = valid;
  assign ifWide.data_i      = data;
  assign ifWide.clr_cnt_i   = clr;
  assign ifNarrow.valid_i   = valid;
  assign ifNarrow.data_i    = data;
  assign ifNarrow.clr_cnt_i = clr;

  prbs_checker #(.WIDTH(WIDTH), .POLINOM(POLY), .LOCK_CNT(LOCKN), .LOSS_CNT(LOSSN), .ERR_W(16))
    dutWide (.clk(clk), .rst(rst), .bus(ifWide));

  prbs_checker #(.WIDTH(WIDTH), .POLINOM(POLY), .LOCK_CNT(LOCKN), .LOSS_CNT(LOSSN), .ERR_W(4))
    dutNarrow (.clk(clk), .rst(rst), .bus(ifNarrow));

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    logic fb;
    fb = ^(x & POLY);
    return (x >> 1) | ({{(WIDTH-1){1'b0}}, fb} << (WIDTH-1));
  endfunction

  function automatic int errWeight(input logic [WIDTH-1:0] d);
`ifdef PRBS_CHECKER_BITCNT_EN
    return $countones(d);
`else
    return 1;
`endif
  endfunction

  task automatic predict(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic c);
    logic [WIDTH-1:0] diff;
    bit hit;
    if (r) begin
      mLocked = 0; mHasPrev = 0; mPrev = '0; mExpect = '0;
      mMatch = 0; mMiss = 0; mErr = 0; mCntWide = 0; mCntNarrow = 0;
      return;
    end
    mErr = 0;
    if (v && !mLocked) begin
      hit = mHasPrev && (d == nxt(mPrev)) && (d != '0);
      mMatch = hit ? mMatch + 1 : 0;
      mPrev = d;
      mHasPrev = 1;
      if (mMatch == LOCKN) begin
        mLocked = 1; mExpect = nxt(d); mMatch = 0; mMiss = 0;
      end
    end else if (v) begin
      diff = d ^ mExpect;
      mExpect = nxt(mExpect);
      if (diff != '0) begin
        mErr = 1;
        mCntWide   = (mCntWide + errWeight(diff) > 65535) ? 65535 : mCntWide + errWeight(diff);
        mCntNarrow = (mCntNarrow + errWeight(diff) > 15) ? 15 : mCntNarrow + errWeight(diff);
        mMiss++;
        if (mMiss == LOSSN) begin
          mLocked = 0; mPrev = d; mHasPrev = 1; mMatch = 0; mMiss = 0;
        end
      end else begin
        mMiss = 0;
      end
    end
    if (c) begin
      mCntWide = 0;
      mCntNarrow = 0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic c);
    expect_t e;
    @(negedge clk);
    rst = r;
    valid = v;
    data = d;
    clr = c;
    predict(r, v, d, c);
    e.locked    = mLocked;
    e.err       = mErr;
    e.cntWide   = 16'(mCntWide);
    e.cntNarrow = 4'(mCntNarrow);
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
    assertCount++;
    if (actual !== required) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, required);
    end
  endtask

  task automatic sendClean(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, gen, 1'b0);
      gen = nxt(gen);
    end
  endtask

  // Monitor: outputs are registered, so every cycle presents a fresh result to check.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbQueue.size() > 0) begin
        e = sbQueue.pop_front();
        checkOutput("locked_o",       16'(ifWide.locked_o),     16'(e.locked));
        checkOutput("err_o",          16'(ifWide.err_o),        16'(e.err));
        checkOutput("err_cnt_o",      ifWide.err_cnt_o,         e.cntWide);
        checkOutput("narrow_locked",  16'(ifNarrow.locked_o),   16'(e.locked));
        checkOutput("narrow_err_o",   16'(ifNarrow.err_o),      16'(e.err));
        checkOutput("narrow_err_cnt", 16'(ifNarrow.err_cnt_o),  16'(e.cntNarrow));
      end
    end
  end

  initial begin
`ifdef PRBS_CHECKER_BITCNT_EN
    flipMask = 10'h007;
`else
    flipMask = 10'h001;
`endif
    gen = 10'h001;

    $display("[TB] reset with active inputs");
    repeat (3) applyStimulus(1'b1, 1'b1, 10'h3FF, 1'b0);
    applyStimulus(1'b0, 1'b0, 10'h3FF, 1'b0);

    $display("[TB] clean acquisition, 100 words");
    sendClean(100);

    $display("[TB] single corrupted word");
    applyStimulus(1'b0, 1'b1, gen ^ flipMask, 1'b0);
    gen = nxt(gen);
    sendClean(3);

    $display("[TB] zero stream after reset");
    applyStimulus(1'b1, 1'b0, 10'h000, 1'b0);
    repeat (50) applyStimulus(1'b0, 1'b1, 10'h000, 1'b0);

    $display("[TB] reacquire then lose lock on 0x155");
    sendClean(12);
    for (int i = 0; i < 20 && mLocked; i++) begin
      applyStimulus(1'b0, 1'b1, 10'h155, 1'b0);
      gen = nxt(gen);
    end
    sendClean(10);

    $display("[TB] gapped errors, saturation and clear");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b1, (i % 2 == 0) ? (gen ^ 10'h001) : gen, 1'b0);
      gen = nxt(gen);
      applyStimulus(1'b0, 1'b0, 10'h2AA, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, gen ^ 10'h001, 1'b1);
    gen = nxt(gen);
    sendClean(3);

    repeat (3) @(negedge clk);
    assertCount++;
    if (sbQueue.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbQueue.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
